alu_issue_stage: RTL

//  Decode/issue stage that produces the operand and field bundle consumed by ALU_32b.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/issue_regfile.sv | 55 +++++
 rtl/alu_issue_stage.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: opcodes, widths and the issue bundle layout.
package alu_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  typedef struct packed {
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] pc;
    logic [19:0]     u_imm20;
    logic [11:0]     imm12;
    logic [4:0]      rs2;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct1;
    logic [4:0]      rd;
  } issue_bundle_t;

  localparam int BUNDLE_W = $bits(issue_bundle_t);

  function automatic logic opc_legal(input logic [6:0] opc);
    case (opc)
      OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC: opc_legal = 1'b1;
      default:                               opc_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/issue_regfile.sv
// Architectural register file: two async read ports with write-through, one sync write port, x0 fixed at 0.
module issue_regfile
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd
);

  logic [XLEN-1:0] mem_r [NREG];

  // Storage update; x0 is never written so it always reads back zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        mem_r[i] <= {XLEN{1'b0}};
      end
    end else if (we && (wa != 5'd0)) begin
      mem_r[wa] <= wd;
    end else begin
      mem_r <= mem_r;
    end
  end

  // Read port 1 with same-cycle write forwarding.
  always_comb begin
    rd1 = {XLEN{1'b0}};
    if (ra1 == 5'd0) begin
      rd1 = {XLEN{1'b0}};
    end else if (we && (wa == ra1)) begin
      rd1 = wd;
    end else begin
      rd1 = mem_r[ra1];
    end
  end

  // Read port 2 with same-cycle write forwarding.
  always_comb begin
    rd2 = {XLEN{1'b0}};
    if (ra2 == 5'd0) begin
      rd2 = {XLEN{1'b0}};
    end else if (we && (wa == ra2)) begin
      rd2 = wd;
    end else begin
      rd2 = mem_r[ra2];
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue stage: reads operands, tracks pending destinations and holds one bundle for execute.
module alu_issue_stage
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] pc,
  output logic [19:0]     u_imm20,
  output logic [11:0]     imm12,
  output logic [4:0]      rs2,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic            funct1,
  output logic [4:0]      rd,
  output logic            illegal,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data
);

  logic [6:0]      opc_s;
  logic [4:0]      rs1_idx_s, rs2_idx_s, rd_idx_s;
  logic            legal_s, hazard_s, accept_s;
  logic [XLEN-1:0] rf_rd1_s, rf_rd2_s;
  logic [NREG-1:0] sb_r, sb_nxt_s;
  logic            out_valid_r, illegal_r;
  issue_bundle_t   bundle_s, bundle_r;

  assign opc_s     = in_instr[6:0];
  assign rd_idx_s  = in_instr[11:7];
  assign rs1_idx_s = in_instr[19:15];
  assign rs2_idx_s = in_instr[24:20];
  assign legal_s   = opc_legal(opc_s);

  issue_regfile u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1   (rs1_idx_s),
    .ra2   (rs2_idx_s),
    .rd1   (rf_rd1_s),
    .rd2   (rf_rd2_s),
    .we    (wb_en),
    .wa    (wb_rd),
    .wd    (wb_data)
  );

  // A register retiring this very cycle no longer blocks its consumer.
  function automatic logic reg_busy(input logic [NREG-1:0] sb, input logic [4:0] r,
                                    input logic we, input logic [4:0] wa);
    reg_busy = sb[r] && !(we && (wa == r));
  endfunction

  // Hazard check; LUI/AUIPC carry immediate bits where rs1 would be, so they never stall.
  always_comb begin
    hazard_s = 1'b0;
    if (opc_s == OPC_OP) begin
      hazard_s = reg_busy(sb_r, rs1_idx_s, wb_en, wb_rd) || reg_busy(sb_r, rs2_idx_s, wb_en, wb_rd);
    end else if (opc_s == OPC_OPIMM) begin
      hazard_s = reg_busy(sb_r, rs1_idx_s, wb_en, wb_rd);
    end else begin
      hazard_s = 1'b0;
    end
  end

  assign in_ready = (!out_valid_r || out_ready) && !hazard_s;
  assign accept_s = in_valid && in_ready;

  // Decode of the incoming word into the bundle that will be registered on accept.
  always_comb begin
    bundle_s          = {BUNDLE_W{1'b0}};
    bundle_s.pc       = in_pc;
    bundle_s.u_imm20  = in_instr[31:12];
    bundle_s.imm12    = in_instr[31:20];
    bundle_s.rs2      = rs2_idx_s;
    bundle_s.opcode   = opc_s;
    bundle_s.funct3   = in_instr[14:12];
    bundle_s.rd       = rd_idx_s;
    if ((opc_s == OPC_LUI) || (opc_s == OPC_AUIPC)) begin
      bundle_s.rs1_data = {XLEN{1'b0}};
    end else begin
      bundle_s.rs1_data = rf_rd1_s;
    end
    if (opc_s == OPC_OP) begin
      bundle_s.rs2_data = rf_rd2_s;
      bundle_s.funct1   = in_instr[30];
    end else if ((opc_s == OPC_OPIMM) && (in_instr[14:12] == 3'b101)) begin
      bundle_s.rs2_data = {XLEN{1'b0}};
      bundle_s.funct1   = in_instr[30];
    end else begin
      bundle_s.rs2_data = {XLEN{1'b0}};
      bundle_s.funct1   = 1'b0;
    end
  end

  // Scoreboard next state: retire first, then mark the new destination so set wins.
  always_comb begin
    sb_nxt_s = sb_r;
    if (wb_en) begin
      sb_nxt_s[wb_rd] = 1'b0;
    end else begin
      sb_nxt_s = sb_r;
    end
    if (accept_s && legal_s && (rd_idx_s != 5'd0)) begin
      sb_nxt_s[rd_idx_s] = 1'b1;
    end else begin
      sb_nxt_s[0] = sb_nxt_s[0];
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_r <= {NREG{1'b0}};
    end else begin
      sb_r <= sb_nxt_s;
    end
  end

  // Output register: loads on a legal accept, holds while execute is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      illegal_r   <= 1'b0;
      bundle_r    <= {BUNDLE_W{1'b0}};
    end else begin
      illegal_r <= accept_s && !legal_s;
      if (accept_s && legal_s) begin
        out_valid_r <= 1'b1;
        bundle_r    <= bundle_s;
      end else if (accept_s || out_ready) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign illegal   = illegal_r;
  assign rs1_data  = bundle_r.rs1_data;
  assign rs2_data  = bundle_r.rs2_data;
  assign pc        = bundle_r.pc;
  assign u_imm20   = bundle_r.u_imm20;
  assign imm12     = bundle_r.imm12;
  assign rs2       = bundle_r.rs2;
  assign opcode    = bundle_r.opcode;
  assign funct3    = bundle_r.funct3;
  assign funct1    = bundle_r.funct1;
  assign rd        = bundle_r.rd;

endmodule
